branch_pc_sequencer: RTL and testbench
======================================

# branch_pc_sequencer

Program-counter sequencer that consumes the BLT/BGE branch-decision flags and the branch immediate and turns them into the registered instruction-fetch address. It sits between the branch comparator and instruction memory. It owns the PC register, redirects on taken branches, and masks wrong-path fetches for a fixed number of cycles after each redirect. It also keeps a saturating count of taken branches for debug.

## Interface
Parameters:
- RESET_PC, 64'h0, PC value loaded on reset.
- PC_STEP, 4, sequential increment in bytes.
- FLUSH_CYCLES, 2, number of cycles Flush stays high after a taken branch; legal range 1..15.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset (0 = in reset).
- Stall  input  1  when 1, freezes all state (PC, FSM, counters).
- Branch  input  1  current instruction is a conditional branch.
- BLT  input  1  branch-less-than condition true.
- BGE  input  1  branch-greater-or-equal condition true.
- Imm  input  64  signed branch offset in halfwords (pre-shift).
- PC_Out  output  64  current fetch address, registered.
- Valid_Out  output  1  PC_Out addresses a valid-path instruction.
- Flush  output  1  wrong-path fetch in progress; downstream must squash.
- Taken_Count  output  32  saturating count of taken branches.

## Operation
- FSM states: BOOT, RUN, FLUSH. Reset forces BOOT.
- Taken condition: Branch & (BLT | BGE), sampled only in RUN with Stall=0. BLT and BGE both high counts as one taken branch. BLT or BGE with Branch=0 is ignored.
- BOOT
  - PC_Out holds RESET_PC.
  - Valid_Out=0, Flush=0.
  - On the first non-stalled edge, go to RUN. PC is not incremented on this edge.
- RUN, not taken: PC_Out <= PC_Out + PC_STEP.
- RUN, taken:
  - PC_Out <= PC_Out + (Imm << 1).
  - Load the flush counter with FLUSH_CYCLES and go to FLUSH.
  - Taken_Count <= Taken_Count + 1, saturating at 32'hFFFF_FFFF.
- FLUSH
  - PC_Out <= PC_Out + PC_STEP every non-stalled edge.
  - Branch, BLT and BGE are ignored.
  - The counter decrements each non-stalled edge. When the counter equals 1 on an edge, go to RUN.
- Output decode:
  - Flush = (state == FLUSH).
  - Valid_Out = (state == RUN).
  - Both are decoded from registered state only, with no combinational path from inputs.
- Arithmetic: all PC adds are 64-bit and wrap modulo 2^64. Imm is sign-correct two's complement; the shift discards Imm[63].
- Stall=1 holds PC_Out, the FSM, the flush counter and Taken_Count. Branch inputs present during a stalled cycle are not sampled.

## Timing
- Reset values: PC_Out=RESET_PC, Valid_Out=0, Flush=0, Taken_Count=0, state=BOOT, flush counter=0.
- Reset assertion takes effect immediately. All outputs take their reset values without waiting for a clock edge.
- Reset mid-FLUSH aborts the flush and the pending redirect. After release, the sequence restarts from BOOT.
- Branch decision latency is one cycle. Inputs sampled at edge N are reflected in PC_Out after edge N.
- After a taken branch at edge N:
  - Flush=1 and Valid_Out=0 for exactly FLUSH_CYCLES non-stalled cycles, covering the target and following fetches.
  - Valid_Out returns to 1 after edge N+FLUSH_CYCLES, provided no stalls occur.
- Stall cycles stretch the FLUSH window cycle-for-cycle. Flush never deasserts during a stall.
- A branch arriving on the edge that leaves FLUSH is ignored. Only RUN-state edges sample branches.

## Test plan
- Reset and boot: RESET_PC=0x1000. Hold reset low, then release with no branches → PC_Out=0x1000 with Valid_Out=0 for one cycle, then 0x1004, 0x1008 with Valid_Out=1.
- Taken BLT: at PC=0x1008, drive Branch=1, BLT=1, Imm=8 → next PC_Out=0x1018. Flush=1 for 2 cycles while PC goes 0x1018 then 0x101C. Valid_Out=1 from 0x1020. Taken_Count=1.
- Not taken and ignored flags:
  - Branch=1 with BLT=BGE=0 → PC+4.
  - Branch=0 with BGE=1 → PC+4, Taken_Count unchanged.
  - Branch=1 with BGE=1 during FLUSH → ignored, no extra redirect.
- Negative offset and wrap:
  - Imm=-4 at PC=0x2000 → PC_Out=0x1FF8.
  - PC=0xFFFF_FFFF_FFFF_FFFC not taken → PC_Out=0x0.
- Stall in FLUSH: take a branch, then assert Stall for 3 cycles in the first flush cycle → PC_Out and Flush are held, and Flush stays high for 2 non-stalled cycles (5 total).
- Async reset mid-flush and saturation:
  - Pulse reset between edges during FLUSH → outputs return to reset values immediately.
  - Force Taken_Count to 0xFFFF_FFFF, then take a branch → it stays 0xFFFF_FFFF.

Source files
------------

// File: rtl/branch_pc_sequencer.sv
// Program-counter sequencer: owns the fetch PC, redirects on taken BLT/BGE
// branches, masks wrong-path fetches for FLUSH_CYCLES and counts taken branches.
module branch_pc_sequencer #(
  parameter logic [63:0] RESET_PC     = 64'h0,
  parameter int unsigned PC_STEP      = 4,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Stall,
  input  logic        Branch,
  input  logic        BLT,
  input  logic        BGE,
  input  logic [63:0] Imm,
  output logic [63:0] PC_Out,
  output logic        Valid_Out,
  output logic        Flush,
  output logic [31:0] Taken_Count
);

  typedef enum logic [1:0] {
    S_BOOT  = 2'd0,
    S_RUN   = 2'd1,
    S_FLUSH = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [3:0]  r_flush_cnt;
  logic [3:0]  w_flush_cnt_nxt;
  logic [63:0] r_pc;
  logic [63:0] w_pc_nxt;
  logic [31:0] r_taken_count;
  logic [31:0] w_taken_count_nxt;
  logic        r_valid;
  logic        r_flush;
  logic        w_taken;
  logic [63:0] w_pc_seq;
  logic [63:0] w_pc_tgt;

  // Offset is in halfwords; the shift drops Imm[63] and keeps two's complement.
  assign w_taken  = Branch & (BLT | BGE);
  assign w_pc_seq = r_pc + 64'(PC_STEP);
  assign w_pc_tgt = r_pc + {Imm[62:0], 1'b0};

  // Next-state, next-PC, flush counter and saturating taken counter.
  always_comb begin
    w_state_nxt       = r_state;
    w_flush_cnt_nxt   = r_flush_cnt;
    w_pc_nxt          = r_pc;
    w_taken_count_nxt = r_taken_count;
    if (!Stall) begin
      case (r_state)
        S_BOOT: begin
          w_state_nxt = S_RUN;
        end
        S_RUN: begin
          if (w_taken) begin
            w_pc_nxt        = w_pc_tgt;
            w_flush_cnt_nxt = 4'(FLUSH_CYCLES);
            w_state_nxt     = S_FLUSH;
            if (r_taken_count != 32'hFFFF_FFFF) begin
              w_taken_count_nxt = r_taken_count + 32'd1;
            end else begin
              w_taken_count_nxt = r_taken_count;
            end
          end else begin
            w_pc_nxt = w_pc_seq;
          end
        end
        S_FLUSH: begin
          w_pc_nxt        = w_pc_seq;
          w_flush_cnt_nxt = r_flush_cnt - 4'd1;
          if (r_flush_cnt == 4'd1) begin
            w_state_nxt = S_RUN;
          end else begin
            w_state_nxt = S_FLUSH;
          end
        end
        default: begin
          w_state_nxt     = S_BOOT;
          w_flush_cnt_nxt = 4'd0;
        end
      endcase
    end else begin
      w_state_nxt = r_state;
    end
  end

  // State registers; status flags are registered from the next state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= S_BOOT;
      r_flush_cnt   <= 4'd0;
      r_pc          <= RESET_PC;
      r_taken_count <= 32'd0;
      r_valid       <= 1'b0;
      r_flush       <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_flush_cnt   <= w_flush_cnt_nxt;
      r_pc          <= w_pc_nxt;
      r_taken_count <= w_taken_count_nxt;
      r_valid       <= (w_state_nxt == S_RUN);
      r_flush       <= (w_state_nxt == S_FLUSH);
    end
  end

  assign PC_Out      = r_pc;
  assign Valid_Out   = r_valid;
  assign Flush       = r_flush;
  assign Taken_Count = r_taken_count;

endmodule

// File: tb/tb_branch_pc_sequencer.sv
// Self-checking bench for branch_pc_sequencer: directed scenarios followed by
// randomized stimulus, all compared against a behavioural model.
module tb_branch_pc_sequencer;

  localparam logic [63:0] RST_PC = 64'h1000;
  localparam int          FLUSH_N = 2;

  logic        clk;
  logic        reset;
  logic        Stall;
  logic        Branch;
  logic        BLT;
  logic        BGE;
  logic [63:0] Imm;
  logic [63:0] PC_Out;
  logic        Valid_Out;
  logic        Flush;
  logic [31:0] Taken_Count;

  int checks_cnt;
  int errors_cnt;

  // Behavioural model: booted flag plus number of wrong-path cycles left.
  logic [63:0] m_pc;
  bit          m_booted;
  int          m_flush_left;
  logic [31:0] m_taken;

  branch_pc_sequencer #(
    .RESET_PC     (RST_PC),
    .PC_STEP      (4),
    .FLUSH_CYCLES (FLUSH_N)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .Stall       (Stall),
    .Branch      (Branch),
    .BLT         (BLT),
    .BGE         (BGE),
    .Imm         (Imm),
    .PC_Out      (PC_Out),
    .Valid_Out   (Valid_Out),
    .Flush       (Flush),
    .Taken_Count (Taken_Count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks_cnt++;
    if (got !== exp) begin
      errors_cnt++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc         = RST_PC;
    m_booted     = 1'b0;
    m_flush_left = 0;
    m_taken      = 32'd0;
  endtask

  task automatic model_edge(input bit st, input bit br, input bit lt, input bit ge,
                            input logic [63:0] im);
    if (st) return;
    if (!m_booted) begin
      m_booted = 1'b1;
    end else if (m_flush_left > 0) begin
      m_pc = m_pc + 64'd4;
      m_flush_left--;
    end else if (br && (lt || ge)) begin
      m_pc = m_pc + im * 64'd2;
      m_flush_left = FLUSH_N;
      if (m_taken != 32'hFFFF_FFFF) m_taken = m_taken + 32'd1;
    end else begin
      m_pc = m_pc + 64'd4;
    end
  endtask

  task automatic compare_all(input string tag);
    check_eq({tag, ".pc"},    PC_Out, m_pc);
    check_eq({tag, ".valid"}, {63'd0, Valid_Out}, {63'd0, (m_booted && m_flush_left == 0)});
    check_eq({tag, ".flush"}, {63'd0, Flush}, {63'd0, (m_flush_left > 0)});
    check_eq({tag, ".cnt"},   {32'd0, Taken_Count}, {32'd0, m_taken});
  endtask

  // Drive inputs after a falling edge, model the rising edge, sample on the next falling edge.
  task automatic step(input string tag, input bit st, input bit br, input bit lt,
                      input bit ge, input logic [63:0] im);
    Stall  = st;
    Branch = br;
    BLT    = lt;
    BGE    = ge;
    Imm    = im;
    @(posedge clk);
    model_edge(st, br, lt, ge, im);
    @(negedge clk);
    compare_all(tag);
  endtask

  task automatic branch_to(input string tag, input logic [63:0] target);
    logic signed [63:0] diff;
    diff = $signed(target - m_pc);
    step(tag, 1'b0, 1'b1, 1'b1, 1'b0, 64'(diff >>> 1));
  endtask

  task automatic check_reset_values(input string tag);
    check_eq({tag, ".pc"},    PC_Out, RST_PC);
    check_eq({tag, ".valid"}, {63'd0, Valid_Out}, 64'd0);
    check_eq({tag, ".flush"}, {63'd0, Flush}, 64'd0);
    check_eq({tag, ".cnt"},   {32'd0, Taken_Count}, 64'd0);
  endtask

  initial begin
    checks_cnt = 0;
    errors_cnt = 0;
    reset  = 1'b0;
    Stall  = 1'b0;
    Branch = 1'b0;
    BLT    = 1'b0;
    BGE    = 1'b0;
    Imm    = 64'd0;
    model_reset();
    #12;
    check_reset_values("rst");
    @(negedge clk);
    reset = 1'b1;

    // Boot and sequential fetch.
    step("boot", 1'b0, 1'b0, 1'b0, 1'b0, 64'd0);
    step("seq1", 1'b0, 1'b0, 1'b0, 1'b0, 64'd0);
    step("seq2", 1'b0, 1'b0, 1'b0, 1'b0, 64'd0);
    check_eq("pc_1008", PC_Out, 64'h1008);

    // Taken BLT, then a branch presented during the flush window.
    step("blt", 1'b0, 1'b1, 1'b1, 1'b0, 64'd8);
    check_eq("blt_tgt", PC_Out, 64'h1018);
    step("fl_ign", 1'b0, 1'b1, 1'b0, 1'b1, 64'd100);
    step("fl_end", 1'b0, 1'b0, 1'b0, 1'b0, 64'd0);
    check_eq("pc_1020", PC_Out, 64'h1020);

    // Ignored flag combinations.
    step("br_noflag", 1'b0, 1'b1, 1'b0, 1'b0, 64'd40);
    step("bge_nobr",  1'b0, 1'b0, 1'b0, 1'b1, 64'd40);

    // Stall inside the flush window stretches it.
    step("st_br", 1'b0, 1'b1, 1'b1, 1'b1, 64'd16);
    for (int i = 0; i < 3; i++) step("st_hold", 1'b1, 1'b1, 1'b1, 1'b0, 64'd4);
    step("st_f1", 1'b0, 1'b0, 1'b0, 1'b0, 64'd0);
    step("st_f2", 1'b0, 1'b0, 1'b0, 1'b0, 64'd0);

    // Negative offset from 0x2000.
    branch_to("to_1ff8", 64'h1FF8);
    step("nf1", 1'b0, 1'b0, 1'b0, 1'b0, 64'd0);
    step("nf2", 1'b0, 1'b0, 1'b0, 1'b0, 64'd0);
    check_eq("pc_2000", PC_Out, 64'h2000);
    step("neg", 1'b0, 1'b1, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC);
    check_eq("neg_tgt", PC_Out, 64'h1FF8);
    step("nf3", 1'b0, 1'b0, 1'b0, 1'b0, 64'd0);
    step("nf4", 1'b0, 1'b0, 1'b0, 1'b0, 64'd0);

    // Wrap past the top of the address space.
    branch_to("to_top", 64'hFFFF_FFFF_FFFF_FFF4);
    step("wf1", 1'b0, 1'b0, 1'b0, 1'b0, 64'd0);
    step("wf2", 1'b0, 1'b0, 1'b0, 1'b0, 64'd0);
    check_eq("pc_top", PC_Out, 64'hFFFF_FFFF_FFFF_FFFC);
    step("wrap", 1'b0, 1'b0, 1'b0, 1'b0, 64'd0);
    check_eq("pc_wrap", PC_Out, 64'h0);

    // Asynchronous reset in the middle of a flush.
    step("ar_br", 1'b0, 1'b1, 1'b1, 1'b0, 64'd64);
    #2;
    reset = 1'b0;
    #1;
    check_reset_values("async_rst");
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    step("ar_boot", 1'b0, 1'b0, 1'b0, 1'b0, 64'd0);

    // Saturation of the taken-branch counter.
    force dut.r_taken_count = 32'hFFFF_FFFF;
    m_taken = 32'hFFFF_FFFF;
    step("sat_hold", 1'b1, 1'b0, 1'b0, 1'b0, 64'd0);
    release dut.r_taken_count;
    step("sat_seq", 1'b0, 1'b0, 1'b0, 1'b0, 64'd0);
    step("sat_br", 1'b0, 1'b1, 1'b1, 1'b0, 64'd12);
    check_eq("sat_cnt", {32'd0, Taken_Count}, 64'hFFFF_FFFF);

    // Reset again, then randomized traffic.
    reset = 1'b0;
    #1;
    check_reset_values("rst2");
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 400; i++) begin
      logic [63:0] im;
      if ($urandom_range(0, 1) == 0) im = 64'($signed($urandom_range(0, 64)) - 32);
      else im = {$urandom, $urandom};
      step("rnd", ($urandom_range(0, 3) == 0), ($urandom_range(0, 2) == 0),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), im);
    end

    $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
    $finish;
  end

endmodule
